// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and the
// default minimum deadtime, also used by the PWM generator.
package pwm_capture_pkg;

   // Capture FSM phases, following the gate sequence high / deadtime / low / deadtime.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HIGH    = 3'd1,
      DT_FALL = 3'd2,
      LOW     = 3'd3,
      DT_RISE = 3'd4
   } pwm_state_e;

   // Minimum legal deadtime in clk cycles; the PWM generator inserts the same amount.
   localparam int PWM_MIN_DT = 5;

endpackage

// File: rtl/pwm_capture_sat.sv
// Saturating up-counter. A clear restarts the count; a clear with enable
// restarts at 1 so the current cycle is included in the new count.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: restart on clear, otherwise count up and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = en_i ? WIDTH'(1) : '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period, high time and both deadtimes of a
// complementary gate pair, and flags overlap, short deadtime and a stuck
// input. Measurements are published on each pwm_hi rise that closes a period.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_WIDTH = 16,
   parameter int DT_WIDTH  = 4,
   parameter int MIN_DT    = PWM_MIN_DT
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 pwm_hi,
   input  logic                 pwm_lo,
   input  logic                 clr_fault,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic [DT_WIDTH-1:0]  dt_fall,
   output logic [DT_WIDTH-1:0]  dt_rise,
   output logic                 meas_valid,
   output logic                 overlap_fault,
   output logic                 dt_fault,
   output logic                 stuck,
   output pwm_state_e           fsm_state
);

   localparam logic [DT_WIDTH-1:0]  MIN_DT_V    = DT_WIDTH'(MIN_DT);
   // The period counter is declared stuck on the cycle it would reach all-ones.
   localparam logic [CNT_WIDTH-1:0] PER_PRE_MAX = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

   // hi_d / lo_d are the one-cycle-delayed gate samples used for edge detection.
   logic hi_d;
   logic lo_d;

   pwm_state_e           state_q;
   pwm_state_e           state_d;
   logic [CNT_WIDTH-1:0] period_q;
   logic [CNT_WIDTH-1:0] high_time_q;
   logic [DT_WIDTH-1:0]  dt_fall_q;
   logic [DT_WIDTH-1:0]  dt_rise_q;
   logic                 meas_valid_q;
   logic                 overlap_fault_q;
   logic                 dt_fault_q;
   logic                 stuck_q;

   logic [CNT_WIDTH-1:0] per_cnt;
   logic [CNT_WIDTH-1:0] high_cnt;
   logic [DT_WIDTH-1:0]  dtf_cnt;
   logic [DT_WIDTH-1:0]  dtr_cnt;

   logic hi_rise;
   logic hi_fall;
   logic lo_rise;
   logic lo_fall;
   logic overlap;

   logic publish;
   logic restart;
   logic stuck_hit;
   logic dtf_done;
   logic dt_short;
   logic cnt_clr;
   logic per_en;
   logic high_en;
   logic dtf_en;
   logic dtr_en;

   assign hi_rise = pwm_hi & ~hi_d;
   assign hi_fall = ~pwm_hi & hi_d;
   assign lo_rise = pwm_lo & ~lo_d;
   assign lo_fall = ~pwm_lo & lo_d;
   assign overlap = pwm_hi & pwm_lo;

   // Next-state decode plus the per-cycle publish/restart/fault events.
   always_comb begin
      state_d   = state_q;
      publish   = 1'b0;
      restart   = 1'b0;
      stuck_hit = 1'b0;
      dtf_done  = 1'b0;
      if (overlap) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hi_rise) begin
                  restart = 1'b1;
                  state_d = HIGH;
               end
            end
            HIGH: begin
               if (hi_fall) begin
                  // Low side rising in the same cycle means a zero deadtime.
                  if (pwm_lo) begin
                     dtf_done = 1'b1;
                     state_d  = LOW;
                  end else begin
                     state_d  = DT_FALL;
                  end
               end
            end
            DT_FALL: begin
               if (hi_rise) begin
                  // Zero-length low phase: dt_rise counter is still 0.
                  publish = 1'b1;
                  restart = 1'b1;
                  state_d = HIGH;
               end else if (lo_rise) begin
                  dtf_done = 1'b1;
                  state_d  = LOW;
               end
            end
            LOW: begin
               if (hi_rise) begin
                  // Low fell and high rose together: zero rising deadtime.
                  publish = 1'b1;
                  restart = 1'b1;
                  state_d = HIGH;
               end else if (lo_fall) begin
                  state_d = DT_RISE;
               end
            end
            DT_RISE: begin
               if (hi_rise) begin
                  publish = 1'b1;
                  restart = 1'b1;
                  state_d = HIGH;
               end
            end
            default: state_d = IDLE;
         endcase
         if ((state_q != IDLE) && !restart && (per_cnt == PER_PRE_MAX)) begin
            stuck_hit = 1'b1;
            state_d   = IDLE;
         end
      end
   end

   // Counter controls. Deadtime counters count both-low cycles, including the
   // edge cycle that enters the deadtime, so the count matches the gap length.
   always_comb begin
      cnt_clr  = restart | overlap | stuck_hit | (state_q == IDLE);
      per_en   = restart | ((state_q != IDLE) & ~overlap & ~stuck_hit);
      high_en  = per_en & pwm_hi;
      dtf_en   = ~pwm_hi & ~pwm_lo & ~stuck_hit &
                 ((state_q == HIGH) | (state_q == DT_FALL));
      dtr_en   = ~pwm_hi & ~pwm_lo & ~stuck_hit &
                 ((state_q == LOW) | (state_q == DT_RISE));
      dt_short = (dtf_done & (dtf_cnt < MIN_DT_V)) |
                 (publish & ((dtf_cnt < MIN_DT_V) | (dtr_cnt < MIN_DT_V)));
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_period_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (cnt_clr),
      .en_i   (per_en),
      .cnt_o  (per_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_high_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (cnt_clr),
      .en_i   (high_en),
      .cnt_o  (high_cnt)
   );

   sat_counter #(.WIDTH(DT_WIDTH)) u_dtf_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (cnt_clr),
      .en_i   (dtf_en),
      .cnt_o  (dtf_cnt)
   );

   sat_counter #(.WIDTH(DT_WIDTH)) u_dtr_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (cnt_clr),
      .en_i   (dtr_en),
      .cnt_o  (dtr_cnt)
   );

   // FSM state, edge-detect samples, published measurements and sticky flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q         <= IDLE;
         hi_d            <= 1'b0;
         lo_d            <= 1'b0;
         period_q        <= '0;
         high_time_q     <= '0;
         dt_fall_q       <= '0;
         dt_rise_q       <= '0;
         meas_valid_q    <= 1'b0;
         overlap_fault_q <= 1'b0;
         dt_fault_q      <= 1'b0;
         stuck_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_d         <= pwm_hi;
         lo_d         <= pwm_lo;
         meas_valid_q <= publish;
         if (publish) begin
            period_q    <= per_cnt;
            high_time_q <= high_cnt;
            dt_fall_q   <= dtf_cnt;
            dt_rise_q   <= dtr_cnt;
         end
         // Set has priority over a same-cycle clear.
         overlap_fault_q <= overlap   | (overlap_fault_q & ~clr_fault);
         dt_fault_q      <= dt_short  | (dt_fault_q & ~clr_fault);
         stuck_q         <= stuck_hit | (stuck_q & ~clr_fault);
      end
   end

   assign period        = period_q;
   assign high_time     = high_time_q;
   assign dt_fall       = dt_fall_q;
   assign dt_rise       = dt_rise_q;
   assign meas_valid    = meas_valid_q;
   assign overlap_fault = overlap_fault_q;
   assign dt_fault      = dt_fault_q;
   assign stuck         = stuck_q;
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: nominal waveform, short deadtime,
// overlap, clear/set priority, reset mid-period and counter saturation.
module tb_pwm_capture;
   import pwm_capture_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk       = 1'b0;
   logic resetn    = 1'b0;
   logic pwm_hi    = 1'b0;
   logic pwm_lo    = 1'b0;
   logic clr_fault = 1'b0;

   always #5 clk = ~clk;

   logic [15:0] period, high_time;
   logic [3:0]  dt_fall, dt_rise;
   logic        meas_valid, overlap_fault, dt_fault, stuck;
   pwm_state_e  fsm_state;

   logic [7:0]  period8, high_time8;
   logic [3:0]  dt_fall8, dt_rise8;
   logic        meas_valid8, overlap_fault8, dt_fault8, stuck8;
   pwm_state_e  fsm_state8;

   pwm_capture u_dut (
      .clk           (clk),
      .resetn        (resetn),
      .pwm_hi        (pwm_hi),
      .pwm_lo        (pwm_lo),
      .clr_fault     (clr_fault),
      .period        (period),
      .high_time     (high_time),
      .dt_fall       (dt_fall),
      .dt_rise       (dt_rise),
      .meas_valid    (meas_valid),
      .overlap_fault (overlap_fault),
      .dt_fault      (dt_fault),
      .stuck         (stuck),
      .fsm_state     (fsm_state)
   );

   pwm_capture #(.CNT_WIDTH(8)) u_dut8 (
      .clk           (clk),
      .resetn        (resetn),
      .pwm_hi        (pwm_hi),
      .pwm_lo        (pwm_lo),
      .clr_fault     (clr_fault),
      .period        (period8),
      .high_time     (high_time8),
      .dt_fall       (dt_fall8),
      .dt_rise       (dt_rise8),
      .meas_valid    (meas_valid8),
      .overlap_fault (overlap_fault8),
      .dt_fault      (dt_fault8),
      .stuck         (stuck8),
      .fsm_state     (fsm_state8)
   );

   // ---------------- bookkeeping ----------------
   int          tests_run    = 0;
   int          tests_failed = 0;
   int          strobe_cnt   = 0;
   logic [15:0] last_period  = '0;
   logic [15:0] last_high    = '0;
   logic [3:0]  last_dtf     = '0;
   logic [3:0]  last_dtr     = '0;

   // ---------------- driver tasks ----------------
   // One clock; outputs sampled 1 time unit after the edge, strobes recorded.
   task automatic tick();
      @(posedge clk);
      #1;
      if (meas_valid === 1'b1) begin
         strobe_cnt++;
         last_period = period;
         last_high   = high_time;
         last_dtf    = dt_fall;
         last_dtr    = dt_rise;
      end
   endtask

   task automatic phase(input logic hi, input logic lo, input int n);
      pwm_hi = hi;
      pwm_lo = lo;
      repeat (n) tick();
   endtask

   task automatic run_period(input int h, input int df, input int l, input int dr);
      phase(1'b1, 1'b0, h);
      phase(1'b0, 1'b0, df);
      phase(1'b0, 1'b1, l);
      phase(1'b0, 1'b0, dr);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      tests_run++;
      if ({period, high_time, dt_fall, dt_rise} !== 40'd0) begin
         tests_failed++;
         $display("FAIL reset_meas: got %h, expected 0", {period, high_time, dt_fall, dt_rise});
      end
      tests_run++;
      if ({meas_valid, overlap_fault, dt_fault, stuck} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b, expected 0000", {meas_valid, overlap_fault, dt_fault, stuck});
      end
      tests_run++;
      if (fsm_state !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d, expected %0d", fsm_state, IDLE);
      end
      resetn = 1'b1;
      phase(1'b0, 1'b0, 3);
   endtask

   task automatic test_nominal();
      strobe_cnt = 0;
      run_period(20, 5, 30, 5);
      run_period(20, 5, 30, 5);
      phase(1'b1, 1'b0, 20);
      phase(1'b0, 1'b0, 5);
      phase(1'b0, 1'b1, 30);
      tests_run++;
      if (strobe_cnt !== 2) begin
         tests_failed++;
         $display("FAIL nominal_strobes: got %0d, expected 2", strobe_cnt);
      end
      tests_run++;
      if ({last_period, last_high} !== {16'd60, 16'd20}) begin
         tests_failed++;
         $display("FAIL nominal_period_high: got %0d/%0d, expected 60/20", last_period, last_high);
      end
      tests_run++;
      if ({last_dtf, last_dtr} !== {4'd5, 4'd5}) begin
         tests_failed++;
         $display("FAIL nominal_dt: got %0d/%0d, expected 5/5", last_dtf, last_dtr);
      end
      tests_run++;
      if ({overlap_fault, dt_fault, stuck} !== 3'b000) begin
         tests_failed++;
         $display("FAIL nominal_faults: got %b, expected 000", {overlap_fault, dt_fault, stuck});
      end
      tests_run++;
      if (fsm_state !== LOW) begin
         tests_failed++;
         $display("FAIL nominal_state: got %0d, expected %0d", fsm_state, LOW);
      end
   endtask

   // Continues from LOW: short rising deadtime of 2 cycles (period 20+5+30+2).
   task automatic test_dt_fault();
      strobe_cnt = 0;
      phase(1'b0, 1'b0, 2);
      tests_run++;
      if (dt_fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL dt_fault_early: got %b, expected 0", dt_fault);
      end
      phase(1'b1, 1'b0, 20);
      tests_run++;
      if (strobe_cnt !== 1) begin
         tests_failed++;
         $display("FAIL dt_short_strobe: got %0d, expected 1", strobe_cnt);
      end
      tests_run++;
      if ({last_period, last_high, last_dtf, last_dtr} !== {16'd57, 16'd20, 4'd5, 4'd2}) begin
         tests_failed++;
         $display("FAIL dt_short_meas: got %0d/%0d/%0d/%0d, expected 57/20/5/2",
                  last_period, last_high, last_dtf, last_dtr);
      end
      tests_run++;
      if (dt_fault !== 1'b1) begin
         tests_failed++;
         $display("FAIL dt_fault_set: got %b, expected 1", dt_fault);
      end
      clr_fault = 1'b1;
      tick();
      clr_fault = 1'b0;
      tests_run++;
      if (dt_fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL dt_fault_clr: got %b, expected 0", dt_fault);
      end
      tests_run++;
      if ({period, dt_rise} !== {16'd57, 4'd2}) begin
         tests_failed++;
         $display("FAIL meas_hold: got %0d/%0d, expected 57/2", period, dt_rise);
      end
   endtask

   // Continues mid-HIGH: one cycle of both gates high.
   task automatic test_overlap();
      pwm_lo = 1'b1;
      tick();
      tests_run++;
      if ({overlap_fault, meas_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL overlap_set: got %b, expected 10", {overlap_fault, meas_valid});
      end
      tests_run++;
      if (fsm_state !== IDLE) begin
         tests_failed++;
         $display("FAIL overlap_state: got %0d, expected %0d", fsm_state, IDLE);
      end
      pwm_lo = 1'b0;
      strobe_cnt = 0;
      phase(1'b1, 1'b0, 10);
      phase(1'b0, 1'b0, 5);
      phase(1'b0, 1'b1, 30);
      phase(1'b0, 1'b0, 5);
      phase(1'b1, 1'b0, 20);
      tests_run++;
      if (strobe_cnt !== 0) begin
         tests_failed++;
         $display("FAIL overlap_first_rise: got %0d strobes, expected 0", strobe_cnt);
      end
      phase(1'b0, 1'b0, 5);
      phase(1'b0, 1'b1, 30);
      phase(1'b0, 1'b0, 5);
      phase(1'b1, 1'b0, 1);
      tests_run++;
      if (strobe_cnt !== 1 || last_period !== 16'd60 || last_high !== 16'd20) begin
         tests_failed++;
         $display("FAIL overlap_second_rise: got %0d strobes p=%0d h=%0d, expected 1 p=60 h=20",
                  strobe_cnt, last_period, last_high);
      end
   endtask

   task automatic test_overlap_clr();
      pwm_lo    = 1'b1;
      clr_fault = 1'b1;
      tick();
      tests_run++;
      if (overlap_fault !== 1'b1) begin
         tests_failed++;
         $display("FAIL overlap_set_wins: got %b, expected 1", overlap_fault);
      end
      pwm_lo = 1'b0;
      tick();
      clr_fault = 1'b0;
      tests_run++;
      if (overlap_fault !== 1'b0) begin
         tests_failed++;
         $display("FAIL overlap_clr: got %b, expected 0", overlap_fault);
      end
   endtask

   task automatic test_reset_mid_low();
      phase(1'b0, 1'b0, 5);
      phase(1'b1, 1'b0, 20);
      phase(1'b0, 1'b0, 5);
      phase(1'b0, 1'b1, 10);
      tests_run++;
      if (fsm_state !== LOW) begin
         tests_failed++;
         $display("FAIL pre_reset_state: got %0d, expected %0d", fsm_state, LOW);
      end
      resetn = 1'b0;
      #2;
      tests_run++;
      if ({period, high_time, dt_fall, dt_rise, meas_valid, overlap_fault, dt_fault, stuck} !== 44'd0) begin
         tests_failed++;
         $display("FAIL async_reset_outputs: got %h, expected 0",
                  {period, high_time, dt_fall, dt_rise, meas_valid, overlap_fault, dt_fault, stuck});
      end
      tests_run++;
      if (fsm_state !== IDLE) begin
         tests_failed++;
         $display("FAIL async_reset_state: got %0d, expected %0d", fsm_state, IDLE);
      end
      tick();
      resetn = 1'b1;
      strobe_cnt = 0;
      phase(1'b0, 1'b1, 20);
      phase(1'b0, 1'b0, 5);
      phase(1'b1, 1'b0, 20);
      tests_run++;
      if (strobe_cnt !== 0) begin
         tests_failed++;
         $display("FAIL post_reset_first_rise: got %0d strobes, expected 0", strobe_cnt);
      end
      phase(1'b0, 1'b0, 5);
      phase(1'b0, 1'b1, 30);
      phase(1'b0, 1'b0, 5);
      phase(1'b1, 1'b0, 1);
      tests_run++;
      if (strobe_cnt !== 1 || last_period !== 16'd60) begin
         tests_failed++;
         $display("FAIL post_reset_second_rise: got %0d strobes p=%0d, expected 1 p=60",
                  strobe_cnt, last_period);
      end
   endtask

   // 8-bit instance: pwm_hi held high from a fresh rise saturates after 255 cycles.
   task automatic test_stuck();
      resetn = 1'b0;
      pwm_hi = 1'b0;
      pwm_lo = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      pwm_hi = 1'b1;
      repeat (254) tick();
      tests_run++;
      if (stuck8 !== 1'b0) begin
         tests_failed++;
         $display("FAIL stuck_early: got %b after 254 cycles, expected 0", stuck8);
      end
      tick();
      tests_run++;
      if (stuck8 !== 1'b1 || fsm_state8 !== IDLE) begin
         tests_failed++;
         $display("FAIL stuck_set: got stuck=%b state=%0d, expected 1 and %0d", stuck8, fsm_state8, IDLE);
      end
      tests_run++;
      if ({period8, high_time8, dt_fall8, dt_rise8, meas_valid8, overlap_fault8, dt_fault8} !== 27'd0) begin
         tests_failed++;
         $display("FAIL stuck_no_meas: got %h, expected 0",
                  {period8, high_time8, dt_fall8, dt_rise8, meas_valid8, overlap_fault8, dt_fault8});
      end
      tests_run++;
      if (stuck !== 1'b0 || fsm_state !== HIGH) begin
         tests_failed++;
         $display("FAIL wide_not_stuck: got stuck=%b state=%0d, expected 0 and %0d", stuck, fsm_state, HIGH);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_nominal();
      test_dt_fault();
      test_overlap();
      test_overlap_clr();
      test_reset_mid_low();
      test_stuck();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
